vertex_ram_wb: RTL and testbench
================================

// Module: vertex_ram_wb
// PURPOSE
//  Banked on-chip vertex store for the SSSP engine: filled with whole cachelines, read one
//  vertex at a time, updated one vertex at a time (relaxed distances), and flushed back as
//  cachelines. Dirty-line tracking lets the flush FSM write back only modified lines over a
//  valid/ready port toward the memory write arbiter.
// PARAMETERS
//  ADDR_W  8   vertex address width. Depth is 2**ADDR_W vertices.
//  VPC     8   vertices per cacheline, power of 2, >=2. Number of banks. LOG_VPC = $clog2(VPC).
//  VBITS   50  vertex_t encoding width inside each 64-bit cacheline slot.
//  Derived: LINE_W = ADDR_W-LOG_VPC. LINES = 2**LINE_W. CL_W = VPC*64.
// PORTS
//  clk          in   1       clock
//  rst          in   1       asynchronous, active-high reset
//  cl_we        in   1       cacheline fill strobe
//  cl_addr      in   ADDR_W  vertex address of the first vertex in the line. Low LOG_VPC bits are ignored.
//  cl_in        in   CL_W    fill data. Slot i = cl_in[i*64 +: 64], decoded with int64_to_vertex.
//  rd_valid     in   1       vertex read request
//  rd_addr      in   ADDR_W  vertex address
//  rd_out_valid out  1       vertex_out is valid
//  vertex_out   out  vertex_t read data
//  upd_valid    in   1       single-vertex write
//  upd_addr     in   ADDR_W  vertex address
//  upd_vertex   in   vertex_t data to write
//  flush_start  in   1       pulse: begin write-back of all dirty lines
//  flush_busy   out  1       flush FSM is not in IDLE
//  flush_done   out  1       one-cycle pulse when the flush completes
//  wb_valid     out  1       write-back line valid
//  wb_ready     in   1       write-back line accepted
//  wb_addr      out  ADDR_W  vertex address of the line (low LOG_VPC bits = 0)
//  wb_cl        out  CL_W    line data. Each slot is the VBITS vertex encoding, zero-extended to 64 bits.
// BEHAVIOUR
//  Reset values: all outputs 0, all dirty bits 0, FSM in IDLE. RAM contents are not cleared.
//  Storage: VPC banks of LINES entries. Bank = addr[LOG_VPC-1:0]. Line = addr[ADDR_W-1:LOG_VPC].
//  Read latency is 2 cycles.
//   - Cycle 1: bank read registered.
//   - Cycle 2: slot select registered.
//   - rd_out_valid follows rd_valid exactly 2 cycles later. Back-to-back requests are accepted every cycle.
//  Fill (cl_we): writes every slot of the line and clears that line's dirty bit.
//  Update (upd_valid): writes one slot and sets that line's dirty bit.
//  Fill and update in the same cycle:
//   - Same line: the fill writes all other slots, the update slot takes upd_vertex, and the line ends dirty.
//   - Different lines: both complete.
//  Read and write of the same vertex in the same cycle: the read returns the old value.
//  A read issued one or more cycles after a write returns the new value.
//  Flush FSM states: IDLE, SCAN, RDLINE, SEND, DONE.
//   - IDLE: flush_start -> SCAN with line ptr = 0.
//   - SCAN: if the line is dirty -> RDLINE. Otherwise advance the pointer (1 line/cycle).
//     After the last line -> DONE.
//   - RDLINE: 1-cycle read of all banks -> SEND.
//   - SEND: wb_valid=1. wb_addr and wb_cl are held stable until wb_ready.
//     On handshake: clear that line's dirty bit, then go to SCAN at the next line, or DONE after the last line.
//   - DONE: flush_done=1 for one cycle -> IDLE.
//  While flush_busy=1:
//   - rd_valid, cl_we and upd_valid are ignored (dropped, no RAM or dirty effect).
//   - rd_out_valid stays 0 for reads issued in this window.
//   - flush_start is ignored.
//   - Reads already in flight when the flush starts still complete normally.
//  Flush with no dirty lines: flush_done asserts LINES+1 cycles after flush_start, with no wb_valid.
//  Reset mid-flush: FSM to IDLE, wb_valid/flush_busy drop immediately, dirty bits cleared.
// TESTING
//  1. Fill line 3 with slot i = i+100, read addrs 24..31 back-to-back -> vertex_out 100..107 with rd_out_valid 2 cycles after each request.
//  2. upd addr 26 = 555 with rd_valid addr 26 in the same cycle -> old value 102. A read on the next cycle -> 555.
//  3. cl_we line 3 (slots 0..7 = 7) together with upd addr 29 = 9 -> readback 7,7,7,7,7,9,7,7, line 3 dirty.
//  4. Dirty lines 0 and 5, flush with wb_ready stalled 3 cycles on the first beat:
//     - wb_addr 0 then 40, data held stable during the stall.
//     - flush_done pulses once; a second flush produces no beats.
//  5. Flush with all lines clean -> no wb_valid, flush_done LINES+1 cycles after start.
//     rd/upd issued while busy have no effect.
//  6. Assert rst while in SEND -> wb_valid=0 asynchronously. After release, flush_busy=0 and a flush produces no beats.

Source files
------------

// File: rtl/vertex_ram_wb.sv
// Banked vertex store for the SSSP engine: cacheline fill, single-vertex read/update,
// and a flush FSM that writes back only the dirty lines over a valid/ready port.
module vertex_ram_wb #(
   parameter int ADDR_W = 8,
   parameter int VPC    = 8,
   parameter int VBITS  = 50
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cl_we,
   input  logic [ADDR_W-1:0]     cl_addr,
   input  logic [VPC*64-1:0]     cl_in,
   input  logic                  rd_valid,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic                  rd_out_valid,
   output logic [VBITS-1:0]      vertex_out,
   input  logic                  upd_valid,
   input  logic [ADDR_W-1:0]     upd_addr,
   input  logic [VBITS-1:0]      upd_vertex,
   input  logic                  flush_start,
   output logic                  flush_busy,
   output logic                  flush_done,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [ADDR_W-1:0]     wb_addr,
   output logic [VPC*64-1:0]     wb_cl,
   output logic [2:0]            dbg_flush_state
);

   localparam int LOG_VPC = $clog2(VPC);
   localparam int LINE_W  = ADDR_W - LOG_VPC;
   localparam int LINES   = 2 ** LINE_W;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SCAN   = 3'd1,
      S_RDLINE = 3'd2,
      S_SEND   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                        state_q, state_d;
   logic [LINE_W-1:0]             ptr_q, ptr_d;
   logic [LINES-1:0]              dirty_q, dirty_d;
   logic [VPC-1:0][VBITS-1:0]     bank_q, bank_d;
   logic                          v1_q, v1_d;
   logic [LOG_VPC-1:0]            sel_q, sel_d;
   logic                          out_valid_q, out_valid_d;
   logic [VBITS-1:0]              vout_q, vout_d;

   logic [VBITS-1:0]              mem_q [VPC][LINES];

   logic                          busy;
   logic                          rd_acc, fill_acc, upd_acc;
   logic                          bank_en;
   logic                          last_line;
   logic [LINE_W-1:0]             raddr;
   logic [LINE_W-1:0]             fill_line, upd_line, rd_line;
   logic [LOG_VPC-1:0]            upd_bank, rd_bank;
   logic                          unused_bits;

   // Host-side traffic is dropped entirely while the flush owns the banks.
   assign busy      = (state_q != S_IDLE);
   assign rd_acc    = rd_valid & ~busy;
   assign fill_acc  = cl_we & ~busy;
   assign upd_acc   = upd_valid & ~busy;

   assign fill_line = cl_addr[ADDR_W-1:LOG_VPC];
   assign upd_line  = upd_addr[ADDR_W-1:LOG_VPC];
   assign upd_bank  = upd_addr[LOG_VPC-1:0];
   assign rd_line   = rd_addr[ADDR_W-1:LOG_VPC];
   assign rd_bank   = rd_addr[LOG_VPC-1:0];

   assign last_line = (ptr_q == LINE_W'(LINES - 1));
   assign raddr     = busy ? ptr_q : rd_line;
   assign bank_en   = rd_acc | (state_q == S_RDLINE);

   always_comb begin
      unused_bits = ^cl_addr[LOG_VPC-1:0];
      for (int b = 0; b < VPC; b++) begin
         unused_bits = unused_bits ^ (^cl_in[b*64+VBITS +: 64-VBITS]);
      end
   end

   // Fill is written before the update so a same-line update slot wins.
   always_ff @(posedge clk) begin
      for (int b = 0; b < VPC; b++) begin
         if (fill_acc) begin
            mem_q[b][fill_line] <= cl_in[b*64 +: VBITS];
         end
         if (upd_acc && (upd_bank == LOG_VPC'(b))) begin
            mem_q[b][upd_line] <= upd_vertex;
         end
      end
   end

   always_comb begin
      bank_d = bank_q;
      if (bank_en) begin
         for (int b = 0; b < VPC; b++) begin
            bank_d[b] = mem_q[b][raddr];
         end
      end
      v1_d        = rd_acc;
      sel_d       = rd_acc ? rd_bank : sel_q;
      out_valid_d = v1_q;
      vout_d      = v1_q ? bank_q[sel_q] : vout_q;
   end

   // wb handshake: wb_valid rises in SEND and stays high with wb_addr/wb_cl frozen
   // until a cycle where wb_ready is also high; that cycle is the transfer.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      dirty_d = dirty_q;
      if (fill_acc) begin
         dirty_d[fill_line] = 1'b0;
      end
      if (upd_acc) begin
         dirty_d[upd_line] = 1'b1;
      end
      case (state_q)
         S_IDLE: begin
            if (flush_start) begin
               state_d = S_SCAN;
               ptr_d   = '0;
            end
         end
         S_SCAN: begin
            if (dirty_q[ptr_q]) begin
               state_d = S_RDLINE;
            end else if (last_line) begin
               state_d = S_DONE;
            end else begin
               ptr_d = ptr_q + LINE_W'(1);
            end
         end
         S_RDLINE: begin
            state_d = S_SEND;
         end
         S_SEND: begin
            if (wb_ready) begin
               dirty_d[ptr_q] = 1'b0;
               if (last_line) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_SCAN;
                  ptr_d   = ptr_q + LINE_W'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         dirty_q     <= '0;
         bank_q      <= '0;
         v1_q        <= 1'b0;
         sel_q       <= '0;
         out_valid_q <= 1'b0;
         vout_q      <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         dirty_q     <= dirty_d;
         bank_q      <= bank_d;
         v1_q        <= v1_d;
         sel_q       <= sel_d;
         out_valid_q <= out_valid_d;
         vout_q      <= vout_d;
      end
   end

   always_comb begin
      wb_cl = '0;
      for (int b = 0; b < VPC; b++) begin
         wb_cl[b*64 +: 64] = 64'(bank_q[b]);
      end
   end

   assign rd_out_valid    = out_valid_q;
   assign vertex_out      = vout_q;
   assign flush_busy      = busy;
   assign flush_done      = (state_q == S_DONE);
   assign wb_valid        = (state_q == S_SEND);
   assign wb_addr         = {ptr_q, {LOG_VPC{1'b0}}};
   assign dbg_flush_state = state_q;

endmodule

// File: tb/tb_vertex_ram_wb.sv
// Directed bench for vertex_ram_wb: array model of memory and dirty lines, expected
// read/beat queues checked every cycle, plus literal values pinning the model.
module tb_vertex_ram_wb;

   localparam int ADDR_W = 8;
   localparam int VPC    = 8;
   localparam int VBITS  = 50;
   localparam int LINES  = 32;
   localparam int CL_W   = VPC * 64;
   localparam int DEPTH  = 256;

   logic              clk;
   logic              rst;
   logic              cl_we;
   logic [ADDR_W-1:0] cl_addr;
   logic [CL_W-1:0]   cl_in;
   logic              rd_valid;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_out_valid;
   logic [VBITS-1:0]  vertex_out;
   logic              upd_valid;
   logic [ADDR_W-1:0] upd_addr;
   logic [VBITS-1:0]  upd_vertex;
   logic              flush_start;
   logic              flush_busy;
   logic              flush_done;
   logic              wb_valid;
   logic              wb_ready;
   logic [ADDR_W-1:0] wb_addr;
   logic [CL_W-1:0]   wb_cl;
   logic [2:0]        dbg_flush_state;

   vertex_ram_wb #(.ADDR_W(ADDR_W), .VPC(VPC), .VBITS(VBITS)) dut (
      .clk(clk), .rst(rst),
      .cl_we(cl_we), .cl_addr(cl_addr), .cl_in(cl_in),
      .rd_valid(rd_valid), .rd_addr(rd_addr),
      .rd_out_valid(rd_out_valid), .vertex_out(vertex_out),
      .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_vertex(upd_vertex),
      .flush_start(flush_start), .flush_busy(flush_busy), .flush_done(flush_done),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_cl(wb_cl),
      .dbg_flush_state(dbg_flush_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- model and scoreboard ----------------
   int checks = 0;
   int failures = 0;

   logic [VBITS-1:0]  model_mem [DEPTH];
   bit                model_dirty [LINES];
   logic [VBITS-1:0]  exp_q[$];
   int                due_q[$];
   logic [ADDR_W-1:0] beat_addr_q[$];
   logic [CL_W-1:0]   beat_cl_q[$];
   logic [ADDR_W-1:0] got_wb_q[$];
   logic [VBITS-1:0]  last_rd;
   int                done_count = 0;
   int                done_cyc = 0;
   int                stall_left = 0;
   bit                chk_en = 0;

   initial begin
      wb_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            if (due_q.size() > 0 && due_q[0] == cyc) begin
               checks++;
               if (rd_out_valid !== 1'b1 || vertex_out !== exp_q[0]) begin
                  failures++;
                  $display("FAIL rd_data cyc=%0d valid=%0b got=%0d exp=%0d",
                           cyc, rd_out_valid, vertex_out, exp_q[0]);
               end
               last_rd = vertex_out;
               void'(due_q.pop_front());
               void'(exp_q.pop_front());
            end else if (rd_out_valid !== 1'b0) begin
               checks++;
               failures++;
               $display("FAIL rd_unexpected cyc=%0d valid=%0b exp=0", cyc, rd_out_valid);
            end
            if (wb_valid === 1'b1) begin
               checks++;
               if (beat_addr_q.size() == 0) begin
                  failures++;
                  $display("FAIL wb_unexpected cyc=%0d addr=%0d exp=no beat", cyc, wb_addr);
                  wb_ready = 1'b1;
               end else begin
                  if (wb_addr !== beat_addr_q[0] || wb_cl !== beat_cl_q[0]) begin
                     failures++;
                     $display("FAIL wb_beat cyc=%0d addr=%0d exp_addr=%0d cl=%h exp_cl=%h",
                              cyc, wb_addr, beat_addr_q[0], wb_cl, beat_cl_q[0]);
                  end
                  if (stall_left > 0) begin
                     wb_ready = 1'b0;
                     stall_left--;
                  end else begin
                     wb_ready = 1'b1;
                     got_wb_q.push_back(wb_addr);
                     void'(beat_addr_q.pop_front());
                     void'(beat_cl_q.pop_front());
                  end
               end
            end else begin
               wb_ready = 1'b0;
            end
            if (flush_done === 1'b1) begin
               done_count++;
               done_cyc = cyc;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   function automatic logic [CL_W-1:0] mk_line(input longint base, input longint inc,
                                                input logic [13:0] hi);
      logic [CL_W-1:0] l;
      l = '0;
      for (int i = 0; i < VPC; i++) begin
         l[i*64 +: 64] = {hi, 50'(base + inc * i)};
      end
      return l;
   endfunction

   task automatic op(input bit rd, input int ra, input bit up, input int ua,
                     input logic [VBITS-1:0] uv, input bit fl, input int fa,
                     input logic [CL_W-1:0] fd, input bit ignored);
      rd_valid   = rd;
      rd_addr    = ADDR_W'(ra);
      upd_valid  = up;
      upd_addr   = ADDR_W'(ua);
      upd_vertex = uv;
      cl_we      = fl;
      cl_addr    = ADDR_W'(fa);
      cl_in      = fd;
      if (!ignored) begin
         if (rd) begin
            exp_q.push_back(model_mem[ra]);
            due_q.push_back(cyc + 2);
         end
         if (fl) begin
            for (int i = 0; i < VPC; i++) model_mem[(fa / VPC) * VPC + i] = fd[i*64 +: VBITS];
            model_dirty[fa / VPC] = 1'b0;
         end
         if (up) begin
            model_mem[ua] = uv;
            model_dirty[ua / VPC] = 1'b1;
         end
      end
      step();
      rd_valid  = 1'b0;
      upd_valid = 1'b0;
      cl_we     = 1'b0;
   endtask

   task automatic fill(input int a, input logic [CL_W-1:0] d);
      op(0, 0, 0, 0, '0, 1, a, d, 0);
   endtask

   task automatic upd(input int a, input logic [VBITS-1:0] v);
      op(0, 0, 1, a, v, 0, 0, '0, 0);
   endtask

   task automatic rd(input int a);
      op(1, a, 0, 0, '0, 0, 0, '0, 0);
   endtask

   task automatic settle();
      for (int i = 0; i < 3; i++) step();
   endtask

   // Expected beats: every dirty line in ascending order, slots zero-extended.
   task automatic build_beats();
      logic [CL_W-1:0] cl;
      for (int l = 0; l < LINES; l++) begin
         if (model_dirty[l]) begin
            cl = '0;
            for (int i = 0; i < VPC; i++) cl[i*64 +: 64] = 64'(model_mem[l * VPC + i]);
            beat_addr_q.push_back(ADDR_W'(l * VPC));
            beat_cl_q.push_back(cl);
            model_dirty[l] = 1'b0;
         end
      end
   endtask

   task automatic do_flush(input int stall, input bit check_time, input bit busy_ops);
      int start;
      int t;
      build_beats();
      stall_left = stall;
      done_count = 0;
      got_wb_q.delete();
      flush_start = 1'b1;
      start = cyc;
      step();
      flush_start = 1'b0;
      if (busy_ops) begin
         op(1, 24, 1, 24, 50'd999, 1, 8, mk_line(5000, 1, 14'd0), 1);
         op(1, 9, 1, 10, 50'd888, 0, 0, '0, 1);
         flush_start = 1'b1;
         step();
         flush_start = 1'b0;
      end
      t = 0;
      while (done_count == 0 && t < 2000) begin
         step();
         t++;
      end
      check("flush_done_seen", done_count, 1);
      settle();
      check("flush_done_once", done_count, 1);
      check("flush_busy_after", flush_busy, 0);
      check("beats_outstanding", beat_addr_q.size(), 0);
      if (check_time) check("flush_done_latency", done_cyc - start, LINES + 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t;
      rst = 1'b1;
      cl_we = 1'b0; cl_addr = '0; cl_in = '0;
      rd_valid = 1'b0; rd_addr = '0;
      upd_valid = 1'b0; upd_addr = '0; upd_vertex = '0;
      flush_start = 1'b0;
      for (int l = 0; l < LINES; l++) model_dirty[l] = 1'b0;
      step();
      step();
      check("reset_rd_out_valid", rd_out_valid, 0);
      check("reset_vertex_out", vertex_out, 0);
      check("reset_flush_busy", flush_busy, 0);
      check("reset_flush_done", flush_done, 0);
      check("reset_wb_valid", wb_valid, 0);
      check("reset_wb_addr", wb_addr, 0);
      check("reset_wb_cl_zero", (wb_cl == '0) ? 1 : 0, 1);
      rst = 1'b0;
      chk_en = 1'b1;
      step();

      // 1: fill line 3 via a non-aligned address, back-to-back reads
      fill(27, mk_line(100, 1, 14'd0));
      for (int a = 24; a < 32; a++) rd(a);
      settle();
      check("t1_last_read", last_rd, 107);

      // 2: read-during-write returns old data, next read returns new
      op(1, 26, 1, 26, 50'd555, 0, 0, '0, 0);
      settle();
      check("t2_old_value", last_rd, 102);
      rd(26);
      settle();
      check("t2_new_value", last_rd, 555);

      // 3: fill and update to the same line in one cycle
      op(0, 0, 1, 29, 50'd9, 1, 24, mk_line(7, 0, 14'd0), 0);
      for (int a = 24; a < 32; a++) rd(a);
      settle();
      check("t3_last_read", last_rd, 7);
      rd(29);
      settle();
      check("t3_slot5", last_rd, 9);
      do_flush(0, 0, 0);
      check("t3_beat_count", got_wb_q.size(), 1);
      if (got_wb_q.size() > 0) check("t3_beat_addr", got_wb_q[0], 24);

      // 4: dirty lines 0 and 5, stalled first beat, then a second empty flush
      fill(0, mk_line(200, 1, 14'h3fff));
      fill(40, mk_line(400, 3, 14'd0));
      upd(3, 50'd1234);
      upd(42, 50'd4321);
      rd(1);
      settle();
      check("t4_truncated_slot", last_rd, 201);
      do_flush(3, 0, 0);
      check("t4_beat_count", got_wb_q.size(), 2);
      if (got_wb_q.size() > 1) begin
         check("t4_beat0_addr", got_wb_q[0], 0);
         check("t4_beat1_addr", got_wb_q[1], 40);
      end
      do_flush(0, 0, 0);
      check("t4_second_flush_beats", got_wb_q.size(), 0);

      // 5: clean flush timing, traffic while busy is dropped
      fill(8, mk_line(60, 1, 14'd0));
      do_flush(0, 1, 1);
      check("t5_beats", got_wb_q.size(), 0);
      rd(24);
      settle();
      check("t5_addr24_unchanged", last_rd, 7);
      rd(9);
      settle();
      check("t5_addr9_unchanged", last_rd, 61);
      do_flush(0, 0, 0);
      check("t5_no_dirty_after_busy", got_wb_q.size(), 0);

      // 6: reset while a beat is waiting in SEND
      fill(16, mk_line(300, 1, 14'd0));
      upd(17, 50'd777);
      build_beats();
      stall_left = 100000;
      flush_start = 1'b1;
      step();
      flush_start = 1'b0;
      t = 0;
      while (wb_valid !== 1'b1 && t < 200) begin
         step();
         t++;
      end
      check("t6_send_reached", wb_valid, 1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("t6_wb_valid_async", wb_valid, 0);
      check("t6_busy_async", flush_busy, 0);
      beat_addr_q.delete();
      beat_cl_q.delete();
      stall_left = 0;
      step();
      step();
      rst = 1'b0;
      step();
      check("t6_busy_after_release", flush_busy, 0);
      do_flush(0, 1, 0);
      check("t6_no_beats_after_reset", got_wb_q.size(), 0);

      settle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
